// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: one tx_start pulse per stored byte, paced by tx_done.
// Optional almost_full output and AF_THRESH parameter: define UART_TX_FIFO_ALMOST_FULL_EN.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
  ,
  parameter int AF_THRESH  = DEPTH - 2
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic [DATA_WIDTH-1:0]      din,
  output logic                       tx_start,
  input  logic                       tx_done,
  output logic                       busy
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
  ,
  output logic                       almost_full
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

  // Handshake: wr_en is a fire-and-forget strobe, accepted only when full=0;
  // tx_start is a one-cycle launch and tx_done a one-cycle completion pulse.
  state_t                state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  push;
  logic                  pop;
  logic [CW-1:0]         count_next;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push     = wr_en && !full;
  assign pop      = (state == IDLE) && !empty;
  assign tx_start = (state == START);
  assign busy     = (state != IDLE);

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CW'(1);
    else if (pop && !push)
      count_next = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      din      <= '0;
    end else begin
      count <= count_next;
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (wr_en && full)
        overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (pop) begin
            din    <= mem[rd_ptr];
            rd_ptr <= rd_ptr + AW'(1);
            state  <= START;
          end
        end
        // An early tx_done during START still counts as completion.
        START:     state <= tx_done ? IDLE : WAIT_DONE;
        WAIT_DONE: if (tx_done) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

`ifdef UART_TX_FIFO_ALMOST_FULL_EN
  always_ff @(posedge clk) begin
    if (rst)
      almost_full <= 1'b0;
    else
      almost_full <= (count_next >= CW'(AF_THRESH));
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus random traffic
// compared each cycle against a queue-based reference model.
module tb_uart_tx_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH+1);

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic [DW-1:0] din;
  logic          tx_start;
  logic          tx_done;
  logic          busy;
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
  logic          almost_full;
`endif

  uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .din(din), .tx_start(tx_start), .tx_done(tx_done), .busy(busy)
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
    , .almost_full(almost_full)
`endif
  );

  // scoreboard / reference model
  int tests  = 0;
  int failed = 0;
  logic [DW-1:0] exp_q[$];
  bit            m_wait;
  bit            m_start;
  bit            m_ovf;
  logic [DW-1:0] m_din;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_wait  = 0;
    m_start = 0;
    m_ovf   = 0;
    m_din   = '0;
  endtask

  // driver: check current cycle's outputs, then apply inputs and advance the model
  task automatic step(input bit r, input bit w, input logic [DW-1:0] d, input bit done);
    int  sz;
    bit  pop;
    @(negedge clk);
    sz = exp_q.size();
    check("count", count, sz);
    check("full", full, sz == DEPTH);
    check("empty", empty, sz == 0);
    check("overflow", overflow, m_ovf);
    check("busy", busy, m_wait);
    check("tx_start", tx_start, m_start);
    check("din", din, m_din);
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
    check("almost_full", almost_full, sz >= DEPTH - 2);
`endif
    rst = r; wr_en = w; wr_data = d; tx_done = done;
    if (r) begin
      model_reset();
    end else begin
      pop     = !m_wait && sz > 0;
      m_start = 0;
      if (m_wait && done) m_wait = 0;
      if (pop) begin
        m_din   = exp_q.pop_front();
        m_wait  = 1;
        m_start = 1;
      end
      if (w) begin
        if (sz < DEPTH) exp_q.push_back(d);
        else m_ovf = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0);
  endtask

  initial begin
    rst = 1; wr_en = 0; wr_data = '0; tx_done = 0;
    repeat (2) @(posedge clk);
    model_reset();
    step(0, 0, '0, 0);

    // single byte latency
    step(0, 1, 8'hA5, 0);
    idle(5);
    step(0, 0, '0, 1);
    idle(3);

    // fill past full, then drain with tx_done 20 cycles after each launch
    for (int i = 0; i < 18; i++) step(0, 1, DW'(i), 0);
    for (int b = 0; b < 17; b++) begin
      idle(19);
      step(0, 0, '0, 1);
    end
    idle(4);

    // write while full in the same cycle as a pop
    step(1, 0, '0, 0);
    for (int i = 0; i < 17; i++) step(0, 1, DW'(8'h40 + i), 0);
    idle(2);
    step(0, 0, '0, 1);
    step(0, 1, 8'hEE, 0);
    idle(3);

    // reset while waiting for tx_done with bytes stored, then stray tx_done
    step(1, 0, '0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, DW'(8'h90 + i), 0);
    idle(3);
    step(1, 0, '0, 0);
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);
    idle(4);

    // random traffic
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 599) == 0, $urandom_range(0, 2) != 0,
           DW'($urandom), $urandom_range(0, 7) == 0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
